// File: rtl/isa_pkg.sv
// Shared ISA definitions used by both the instruction encoder/loader and the
// CPU instruction decoder: format codes, per-format sub-opcode limits,
// condition codes, field widths, fixed opcode prefixes, the request payload
// and the list of two-word opcodes.
package isa_pkg;

   localparam int unsigned INSTR_W = 16;
   localparam int unsigned FMT_W   = 3;
   localparam int unsigned SUBOP_W = 7;
   localparam int unsigned COND_W  = 4;
   localparam int unsigned REG_W   = 3;
   localparam int unsigned IMM_W   = 16;

   // Immediate sub-field widths carried inside word0
   localparam int unsigned DIRECT_ADDR_W = 12;
   localparam int unsigned BIT_IDX_W     = 4;
   localparam int unsigned CTRL_OFF_W    = 3;

   typedef enum logic [FMT_W-1:0] {
      FMT_SREG     = 3'd0,
      FMT_SREG_BA  = 3'd1,
      FMT_DREG     = 3'd2,
      FMT_TREG     = 3'd3,
      FMT_DIRECT   = 3'd4,
      FMT_CTRL     = 3'd5,
      FMT_CTRL_OFF = 3'd6,
      FMT_RSVD     = 3'd7
   } fmt_e;

   localparam logic [COND_W-1:0] COND_ALWAYS  = 4'b0110;
   localparam logic [COND_W-1:0] COND_INVALID = 4'b1110;

   // Opcode prefixes that select the format in the top bits of word0
   localparam logic [2:0] PFX_SREG     = 3'b000;
   localparam logic [2:0] PFX_SREG_BA  = 3'b001;
   localparam logic [1:0] PFX_DREG     = 2'b01;
   localparam logic [1:0] PFX_TREG     = 2'b10;
   localparam logic [1:0] PFX_DIRECT   = 2'b11;
   localparam logic [4:0] PFX_CTRL     = 5'b11110;
   localparam logic [4:0] PFX_CTRL_OFF = 5'b11111;

   // Legal sub-opcode limits per format (SREG is {0} plus LO..HI)
   localparam logic [SUBOP_W-1:0] SREG_LO      = 7'd3;
   localparam logic [SUBOP_W-1:0] SREG_HI      = 7'd12;
   localparam logic [SUBOP_W-1:0] SREG_BA_N    = 7'd4;
   localparam logic [SUBOP_W-1:0] DREG_N       = 7'd16;
   localparam logic [SUBOP_W-1:0] TREG_N       = 7'd2;
   localparam logic [SUBOP_W-1:0] DIRECT_N     = 7'd3;
   localparam logic [SUBOP_W-1:0] CTRL_MAX     = 7'd16;
   localparam logic [SUBOP_W-1:0] CTRL_OFF_N   = 7'd2;

   // SREG sub-opcodes followed by a 16-bit immediate word: LDI, AIM, SIM
   localparam int unsigned N_TWO_WORD = 3;
   localparam logic [SUBOP_W-1:0] TWO_WORD_OPS [N_TWO_WORD] = '{7'd10, 7'd11, 7'd12};

   typedef struct packed {
      fmt_e               fmt;
      logic [SUBOP_W-1:0] subop;
      logic [COND_W-1:0]  cond;
      logic [REG_W-1:0]   ra;
      logic [REG_W-1:0]   rb;
      logic [REG_W-1:0]   rc;
      logic [IMM_W-1:0]   imm;
   } instr_req_t;

   function automatic logic is_two_word_op(input fmt_e f, input logic [SUBOP_W-1:0] s);
      logic hit;
      hit = 1'b0;
      for (int i = 0; i < int'(N_TWO_WORD); i++) begin
         if (s == TWO_WORD_OPS[i]) hit = 1'b1;
      end
      return (f == FMT_SREG) && hit;
   endfunction

endpackage

// File: rtl/instr_field_packer.sv
// Combinational instruction packer: turns one field-level request into the
// first 16-bit instruction word and classifies it.
//   req      : request fields (format, sub-opcode, condition, registers, imm)
//   word0    : packed first instruction word
//   two_word : legal request that is followed by imm as a second word
//   legal    : format, sub-opcode and condition are all acceptable
module instr_field_packer
   import isa_pkg::*;
(
   input  instr_req_t         req,
   output logic [INSTR_W-1:0] word0,
   output logic               two_word,
   output logic               legal
);

   logic subop_ok;
   logic cond_ok;

   // Per-format packing and sub-opcode range check
   always_comb begin
      word0    = '0;
      subop_ok = 1'b0;
      cond_ok  = (req.cond != COND_INVALID);
      case (req.fmt)
         FMT_SREG: begin
            word0    = {PFX_SREG, req.subop[5:0], req.cond, req.ra};
            subop_ok = (req.subop == '0) ||
                       ((req.subop >= SREG_LO) && (req.subop <= SREG_HI));
         end
         FMT_SREG_BA: begin
            word0    = {PFX_SREG_BA, req.subop[1:0], req.cond, req.ra,
                        req.imm[BIT_IDX_W-1:0]};
            subop_ok = (req.subop < SREG_BA_N);
         end
         FMT_DREG: begin
            word0    = {PFX_DREG, req.subop[3:0], req.cond, req.ra, req.rc};
            subop_ok = (req.subop < DREG_N);
         end
         FMT_TREG: begin
            word0    = {PFX_TREG, req.subop[0], req.cond, req.ra, req.rb, req.rc};
            subop_ok = (req.subop < TREG_N);
         end
         FMT_DIRECT: begin
            // No condition field in the word; only the "always" code is meaningful
            word0    = {PFX_DIRECT, req.subop[1:0], req.imm[DIRECT_ADDR_W-1:0]};
            subop_ok = (req.subop < DIRECT_N);
            cond_ok  = (req.cond == COND_ALWAYS);
         end
         FMT_CTRL: begin
            word0    = {PFX_CTRL, req.subop, req.cond};
            subop_ok = (req.subop <= CTRL_MAX);
         end
         FMT_CTRL_OFF: begin
            word0    = {PFX_CTRL_OFF, req.subop[3:0], req.cond,
                        req.imm[CTRL_OFF_W-1:0]};
            subop_ok = (req.subop < CTRL_OFF_N);
         end
         default: begin
            word0    = '0;
            subop_ok = 1'b0;
         end
      endcase
   end

   assign legal    = subop_ok & cond_ok;
   assign two_word = legal & is_two_word_op(req.fmt, req.subop);

endmodule

// File: rtl/instr_encoder_loader.sv
// Program loader: accepts field-level instruction requests over valid/ready,
// packs them and writes the words sequentially into the instruction RAM.
//   clk, rst_n          : clock, asynchronous active-low reset
//   restart             : synchronous clear of pointer, error and pending word1
//   in_valid / in_ready : request handshake
//   fmt..imm            : request fields
//   ram_wren/addr/data  : registered instruction RAM write port
//   word_count, full    : words written since restart, RAM full
//   err, rej            : sticky reject flag, one-cycle reject pulse
module instr_encoder_loader
   import isa_pkg::*;
#(
   parameter int unsigned ADDR_W     = 12,
   parameter int unsigned START_ADDR = 0
)(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                restart,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [FMT_W-1:0]    fmt,
   input  logic [SUBOP_W-1:0]  subop,
   input  logic [COND_W-1:0]   cond,
   input  logic [REG_W-1:0]    ra,
   input  logic [REG_W-1:0]    rb,
   input  logic [REG_W-1:0]    rc,
   input  logic [IMM_W-1:0]    imm,
   output logic                ram_wren,
   output logic [ADDR_W-1:0]   ram_addr,
   output logic [INSTR_W-1:0]  ram_data,
   output logic [ADDR_W:0]     word_count,
   output logic                full,
   output logic                err,
   output logic                rej
);

   localparam int unsigned CNT_W = ADDR_W + 1;
   localparam logic [CNT_W-1:0] CAPACITY  = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [CNT_W-1:0] LAST_SLOT = CAPACITY - CNT_W'(1);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_EXT  = 1'b1
   } state_e;

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    wc_q, wc_d;
   logic                wren_q, wren_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [INSTR_W-1:0]  data_q, data_d;
   logic [INSTR_W-1:0]  word1_q, word1_d;
   logic                err_q, err_d;
   logic                rej_q, rej_d;

   instr_req_t          req;
   logic [INSTR_W-1:0]  word0;
   logic                two_word;
   logic                legal;
   logic                accept;
   logic [ADDR_W-1:0]   wr_addr;

   assign req = '{fmt:   fmt_e'(fmt),
                  subop: subop,
                  cond:  cond,
                  ra:    ra,
                  rb:    rb,
                  rc:    rc,
                  imm:   imm};

   instr_field_packer u_packer (
      .req      (req),
      .word0    (word0),
      .two_word (two_word),
      .legal    (legal)
   );

   assign full     = (wc_q == CAPACITY);
   assign in_ready = (state_q == ST_IDLE) & ~full & ~restart;
   assign accept   = in_valid & in_ready;
   // Wraps naturally modulo 2**ADDR_W
   assign wr_addr  = ADDR_W'(START_ADDR) + wc_q[ADDR_W-1:0];

   // Next-state, write and reject decisions
   always_comb begin
      state_d = state_q;
      wc_d    = wc_q;
      wren_d  = 1'b0;
      addr_d  = addr_q;
      data_d  = data_q;
      word1_d = word1_q;
      err_d   = err_q;
      rej_d   = 1'b0;

      if (restart) begin
         state_d = ST_IDLE;
         wc_d    = '0;
         err_d   = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  // A two-word form needs both slots; never write half of it
                  if (!legal || (two_word && (wc_q == LAST_SLOT))) begin
                     rej_d = 1'b1;
                     err_d = 1'b1;
                  end else begin
                     wren_d = 1'b1;
                     addr_d = wr_addr;
                     data_d = word0;
                     wc_d   = wc_q + CNT_W'(1);
                     if (two_word) begin
                        word1_d = imm;
                        state_d = ST_EXT;
                     end
                  end
               end
            end
            ST_EXT: begin
               wren_d  = 1'b1;
               addr_d  = wr_addr;
               data_d  = word1_q;
               wc_d    = wc_q + CNT_W'(1);
               state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         wc_q    <= '0;
         wren_q  <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
         word1_q <= '0;
         err_q   <= 1'b0;
         rej_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         wc_q    <= wc_d;
         wren_q  <= wren_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         word1_q <= word1_d;
         err_q   <= err_d;
         rej_q   <= rej_d;
      end
   end

   assign ram_wren   = wren_q;
   assign ram_addr   = addr_q;
   assign ram_data   = data_q;
   assign word_count = wc_q;
   assign err        = err_q;
   assign rej        = rej_q;

endmodule
